multicore_system_ram_copier: RTL
================================

# multicore_system_ram_copier

Avalon-MM master that drives the on-chip RAM slave port of a core in the multicore system, copying a block of 32-bit words from one word address range to another inside the same 1024-word RAM. Software on the owning core, or the system controller, supplies source, destination and length, then pulses `start`. The block sequences single-port read/write accesses against the RAM's fixed one-cycle read latency and signals completion.

## Interface
- `ADDR_W`, 10, word-address width of the RAM port (1024 words)
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`
- `clk`  in  1  system clock, shared with the RAM
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle request; sampled only in IDLE
- `src_addr`  in  ADDR_W  first source word address, latched on accepted `start`
- `dst_addr`  in  ADDR_W  first destination word address, latched on accepted `start`
- `len`  in  ADDR_W+1  word count, 0..1024; values above 1024 are clamped to 1024
- `fill_mode`  in  1  selects fill instead of copy (see Configuration)
- `fill_value`  in  DATA_W  pattern written in fill mode
- `busy`  out  1  high while a transfer is in progress
- `done`  out  1  one-cycle pulse at the end of a transfer
- `m_address`  out  ADDR_W  RAM word address
- `m_byteenable`  out  DATA_W/8  always all ones
- `m_chipselect`  out  1  access strobe
- `m_write`  out  1  1 = write, 0 = read (valid with `m_chipselect`)
- `m_writedata`  out  DATA_W  write data
- `m_readdata`  in  DATA_W  RAM read data, valid exactly one cycle after a read strobe
- `m_clken`  out  1  RAM clock enable; held 1 except in reset

## Operation
- FSM states: IDLE, READ, LATCH, WRITE, FINISH.
- IDLE, `start`=1: latch `src`, `dst`, and `cnt` = clamp(`len`).
  - If `cnt`=0, go to FINISH.
  - Otherwise go to READ (or WRITE in fill mode).
- READ: `m_chipselect`=1, `m_write`=0, `m_address`=src. Next state LATCH.
- LATCH: `m_chipselect`=0. Capture `m_readdata` into the data register. Next state WRITE.
- WRITE: `m_chipselect`=1, `m_write`=1, `m_address`=dst, `m_writedata`=data register.
  - src+1, dst+1 (both mod 2^ADDR_W), cnt-1.
  - If cnt was 1, go to FINISH; else go to READ (or stay in WRITE in fill mode).
- FINISH: `done`=1 for this cycle only, `busy`=0. Next state IDLE.
- Address arithmetic wraps: word 1023 is followed by word 0.
- The copy is always ascending.
  - With overlapping ranges and dst > src, already-copied words are re-read. The result is deterministic (the pattern repeats with period dst-src) and is the defined behaviour.
- `start` in any state other than IDLE is ignored; no queueing.
- `m_byteenable` = all ones and `m_clken` = 1 at all times out of reset.
- `m_chipselect` is low in IDLE, LATCH and FINISH.

## Timing
- Reset values: `busy`=0, `done`=0, `m_chipselect`=0, `m_write`=0, `m_address`=0, `m_writedata`=0, `m_byteenable`=all ones, `m_clken`=0. State = IDLE.
- Reset asserted mid-transfer: outputs take reset values immediately. A write in flight may or may not land. No resume.
- `start` sampled at edge 0 (IDLE): `busy`=1 from cycle 1, and the first READ strobe is in cycle 1.
- Copy of N≥1 words: 3 cycles per word. The last WRITE is in cycle 3N, and `done` pulses in cycle 3N+1 with `busy`=0.
- N=0: `done` pulses in cycle 1; `busy` stays 0; no bus strobes.
- Fill of N words: WRITE in cycles 1..N; `done` in cycle N+1.
- A `start` coincident with the `done` cycle is ignored. A `start` in the cycle after `done` is accepted.

## Configuration
- `RAM_COPIER_FILL_EN` defined: when `fill_mode`=1 at `start`, READ and LATCH are skipped and `fill_value` is written to N consecutive words from `dst_addr`, 1 word per cycle. `src_addr` is ignored.
- `RAM_COPIER_FILL_EN` undefined: `fill_mode` and `fill_value` are ignored (left unconnected internally), and every transfer is a copy.

## Test plan
- Copy: RAM[0..3]=0x11,0x22,0x33,0x44; start src=0 dst=100 len=4 -> RAM[100..103] match; `done` in cycle 13; exactly 4 read and 4 write strobes.
- Wrap: src=1022 dst=10 len=4 -> words 1022,1023,0,1 land at 10..13; the write address sequence is 10,11,12,13.
- Zero and clamp: len=0 -> `done` in cycle 1 with no strobes. len=2047 -> 1024 words copied and `done` in cycle 3073.
- Overlap: RAM[0]=0xA, RAM[1]=0xB; src=0 dst=2 len=6 -> RAM[2..7]=A,B,A,B,A,B.
- Reset mid-transfer: assert `reset` during the 3rd WRITE -> all outputs at reset values within the same cycle; a new start then completes correctly.
- Fill (macro defined): fill_value=0xDEADBEEF, dst=500, len=8 -> RAM[500..507]=0xDEADBEEF and `done` in cycle 9. With the macro undefined, the same stimulus performs a copy.

Source files
------------

// File: rtl/multicore_system_ram_copier_if.sv
// Avalon-MM bus between the RAM copier (master) and a core's on-chip RAM slave port.
`timescale 1ns/1ps
interface multicore_system_ram_copier_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m_address;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_chipselect;
  logic                m_write;
  logic [DATA_W-1:0]   m_writedata;
  logic [DATA_W-1:0]   m_readdata;
  logic                m_clken;

  modport master (
    output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    output m_readdata
  );
endinterface

// File: rtl/multicore_system_ram_copier.sv
// Block copier for a 1024-word single-port RAM with one-cycle read latency.
// Optional fill mode is compiled in when RAM_COPIER_FILL_EN is defined.
`timescale 1ns/1ps
module multicore_system_ram_copier #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     len,
  input  logic                fill_mode,
  input  logic [DATA_W-1:0]   fill_value,
  output logic                busy,
  output logic                done,
  multicore_system_ram_copier_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, FINISH} state_t;

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W+1)'(1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   src_reg, dst_reg;
  logic [ADDR_W:0]     cnt_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                fill_reg;
  logic [ADDR_W:0]     len_clamped;
  logic                fill_req;
  logic [DATA_W-1:0]   fill_word;

`ifdef RAM_COPIER_FILL_EN
  assign fill_req  = fill_mode;
  assign fill_word = fill_value;
`else
  logic unused_fill;
  assign unused_fill = ^{fill_mode, fill_value};
  assign fill_req    = 1'b0;
  assign fill_word   = '0;
`endif

  assign len_clamped = (len > MAX_CNT) ? MAX_CNT : len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len_clamped == '0) state_next = FINISH;
          else if (fill_req)     state_next = WRITE;
          else                   state_next = READ;
        end
      end
      READ:   state_next = LATCH;
      LATCH:  state_next = WRITE;
      WRITE: begin
        if (cnt_reg == ONE_CNT) state_next = FINISH;
        else if (fill_reg)      state_next = WRITE;
        else                    state_next = READ;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fill mode preloads the pattern into the data register so WRITE needs no mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_reg  <= '0;
      dst_reg  <= '0;
      cnt_reg  <= '0;
      data_reg <= '0;
      fill_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            src_reg  <= src_addr;
            dst_reg  <= dst_addr;
            cnt_reg  <= len_clamped;
            fill_reg <= fill_req;
            if (fill_req) data_reg <= fill_word;
          end
        end
        LATCH: data_reg <= bus.m_readdata;
        WRITE: begin
          src_reg <= src_reg + 1'b1;
          dst_reg <= dst_reg + 1'b1;
          cnt_reg <= cnt_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy                = 1'b0;
    done                = 1'b0;
    bus.m_chipselect    = 1'b0;
    bus.m_write         = 1'b0;
    bus.m_address       = '0;
    bus.m_writedata     = '0;
    case (state_reg)
      READ: begin
        busy             = 1'b1;
        bus.m_chipselect = 1'b1;
        bus.m_address    = src_reg;
      end
      LATCH: busy = 1'b1;
      WRITE: begin
        busy             = 1'b1;
        bus.m_chipselect = 1'b1;
        bus.m_write      = 1'b1;
        bus.m_address    = dst_reg;
        bus.m_writedata  = data_reg;
      end
      FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign bus.m_byteenable = '1;
  assign bus.m_clken      = ~reset;

endmodule
